fifo_serial_tx: RTL
===================

Name: fifo_serial_tx

Overview:
- Drain-side companion to the team's synchronous FIFO.
- Pops words from a show-ahead FIFO read port (ren/rdata/empty) and sends each word as an asynchronous serial frame on a single line:
  - start bit (0);
  - data_bw data bits, LSB first;
  - optional parity bit;
  - stop bit (1).
- Sits between the FIFO read port and a chip-level serial output pin.

Parameters:
- data_bw, 4, word width; must equal the FIFO data_bw.
- clks_per_bit, 4, clk cycles per serial bit; legal range >= 1.
- parity_mode, 0, parity bit: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- reset  input  1  synchronous reset, active-high.
- tx_en  input  1  enables starting new frames; does not abort a frame in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  data_bw  FIFO head word; valid whenever fifo_empty=0 (show-ahead, combinational).
- fifo_ren  output  1  pop strobe to the FIFO; one cycle per word.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is being transmitted.
- frame_done  output  1  one-cycle pulse in the last cycle of a stop bit.

Behaviour:
- Interface decision: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values (reset=1 at a clk edge):
  - state=IDLE, tx=1, busy=0, frame_done=0, all counters 0.
  - fifo_ren is forced 0 whenever reset=1.
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when parity_mode=0.
- Each non-IDLE state holds for exactly clks_per_bit cycles, using clk_cnt from 0 to clks_per_bit-1.
  - DATA repeats once per bit; bit_cnt runs 0..data_bw-1.
- tx is registered and driven by state:
  - IDLE = 1, START = 0, DATA = shift_reg[0], PARITY = par_bit, STOP = 1.
- Pop condition: fifo_ren = !reset && tx_en && !fifo_empty && (state==IDLE || (state==STOP && clk_cnt==clks_per_bit-1)).
  - fifo_ren is combinational.
  - In the same cycle as a pop:
    - shift_reg <= fifo_rdata;
    - par_bit <= ^fifo_rdata (even) or ~^fifo_rdata (odd);
    - next state = START, clk_cnt <= 0.
- Pop-to-line latency: tx goes 0 on the first clk edge after the pop cycle.
- Back-to-back frames:
  - If the pop condition holds in the last STOP cycle, the next START follows with no idle gap.
  - Frame period is exactly (data_bw+2+(parity_mode!=0))*clks_per_bit cycles.
- Shifting: shift_reg shifts right by 1 at the end of each DATA bit period.
- State transitions:
  - After bit data_bw-1 → PARITY, or → STOP if parity_mode=0.
  - After STOP with no pop → IDLE.
- busy=1 in every non-IDLE state, and 0 in IDLE.
- frame_done=1 only during the last STOP cycle, and is registered-aligned with tx.
- tx_en deasserted mid-frame: the current frame completes, then the block returns to IDLE with no further pops.
- fifo_empty=1: no pop occurs and tx stays 1; fifo_rdata is ignored.
- Reset mid-frame: the frame is aborted and the popped word is lost; tx=1 after the reset edge.
- Counter widths: clk_cnt is $clog2(clks_per_bit)+1 bits and bit_cnt is $clog2(data_bw)+1 bits; neither may overflow.
- clks_per_bit=1 is legal: each bit lasts one cycle, and back-to-back frames still have no gap.

Test Plan:
Default parameters unless noted; cycle 0 = pop cycle.
- Reset held 3 cycles, fifo_empty=0, tx_en=1 → fifo_ren=0, tx=1, busy=0 throughout reset.
- Single word 4'b1011, tx_en=1:
  - fifo_ren=1 at cycle 0 only.
  - tx from cycle 1 = 0,1,1,0,1,1, each held 4 cycles.
  - frame_done at cycle 24; busy=0 and tx=1 at cycle 25.
- Words 4'h5 then 4'hA queued → pops at cycles 0 and 24; line shows 0,1,0,1,0,1 then 0,0,1,0,1,1 with no idle cycle between.
- fifo_empty=1 for 50 cycles, or tx_en=0 with a non-empty FIFO → fifo_ren never asserts, tx=1, busy=0.
- parity_mode=1, word 4'b0111 → parity bit 1 at cycles 21-24, stop at 25-28, frame_done at 28.
- parity_mode=2, word 4'b0111 → parity bit 0 at cycles 21-24, stop at 25-28.
- Single word 4'b1011, reset asserted at cycle 10 for 1 cycle → tx=1, busy=0 from cycle 11; next frame starts on the first pop after reset.

Source files
------------

// File: rtl/fifo_serial_tx_if.sv
// Purpose: bundles the show-ahead FIFO read port that the serial transmitter
// drains. The transmitter decides when to pop, so it takes the master side;
// the FIFO (or a bench model of it) takes the slave side.
// Signals:
//   fifo_empty  FIFO empty flag (FIFO -> transmitter)
//   fifo_rdata  FIFO head word, valid whenever fifo_empty=0 (FIFO -> transmitter)
//   fifo_ren    one-cycle pop strobe (transmitter -> FIFO)
interface fifo_serial_tx_if #(
  parameter int data_bw = 4
);
  logic               fifo_empty;
  logic [data_bw-1:0] fifo_rdata;
  logic               fifo_ren;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_ren
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_ren
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// Purpose: pops words from a show-ahead FIFO and sends each one as an
// asynchronous serial frame: start bit (0), data_bw data bits LSB first,
// optional parity bit, stop bit (1). Back-to-back frames have no idle gap.
// Ports:
//   clk         clock, all logic on its rising edge
//   reset       synchronous active-high reset
//   tx_en       allows new frames to start; never aborts a frame in progress
//   fifo        FIFO read port (empty / rdata / ren), master side
//   tx          registered serial line, idle high
//   busy        registered, high while a frame is on the line
//   frame_done  registered one-cycle pulse in the last cycle of the stop bit
module fifo_serial_tx #(
  parameter int data_bw      = 4,
  parameter int clks_per_bit = 4,
  parameter int parity_mode  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  fifo_serial_tx_if.master  fifo,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int cw = $clog2(clks_per_bit) + 1;
  localparam int bw = $clog2(data_bw) + 1;
  localparam logic [cw-1:0] last_cnt = cw'(clks_per_bit - 1);
  localparam logic [cw-1:0] cnt_one  = cw'(1);
  localparam logic [bw-1:0] last_bit = bw'(data_bw - 1);
  localparam logic [bw-1:0] bit_one  = bw'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state;
  logic [cw-1:0]      clk_cnt;
  logic [bw-1:0]      bit_cnt;
  logic [data_bw-1:0] shift_reg;
  logic [data_bw-1:0] shift_next;
  logic               par_bit;

  assign shift_next = shift_reg >> 1;

  // A word may be popped from IDLE, or in the final stop-bit cycle so the
  // next start bit follows immediately with no idle gap.
  assign fifo.fifo_ren = !reset && tx_en && !fifo.fifo_empty &&
                         (state == IDLE || (state == STOP && clk_cnt == last_cnt));

  // Single FSM. tx/busy/frame_done are assigned with the value belonging to
  // the state being entered, so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fifo.fifo_ren) begin
        state     <= START;
        clk_cnt   <= '0;
        bit_cnt   <= '0;
        shift_reg <= fifo.fifo_rdata;
        par_bit   <= (parity_mode == 2) ? ~^fifo.fifo_rdata : ^fifo.fifo_rdata;
        tx        <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
          START: begin
            if (clk_cnt == last_cnt) begin
              state   <= DATA;
              clk_cnt <= '0;
              bit_cnt <= '0;
              tx      <= shift_reg[0];
            end else begin
              clk_cnt <= clk_cnt + cnt_one;
            end
          end
          DATA: begin
            if (clk_cnt == last_cnt) begin
              clk_cnt   <= '0;
              shift_reg <= shift_next;
              if (bit_cnt == last_bit) begin
                bit_cnt <= '0;
                if (parity_mode != 0) begin
                  state <= PARITY;
                  tx    <= par_bit;
                end else begin
                  state      <= STOP;
                  tx         <= 1'b1;
                  // A one-cycle stop bit is its own last cycle
                  frame_done <= (clks_per_bit == 1);
                end
              end else begin
                bit_cnt <= bit_cnt + bit_one;
                tx      <= shift_next[0];
              end
            end else begin
              clk_cnt <= clk_cnt + cnt_one;
            end
          end
          PARITY: begin
            if (clk_cnt == last_cnt) begin
              state      <= STOP;
              clk_cnt    <= '0;
              tx         <= 1'b1;
              frame_done <= (clks_per_bit == 1);
            end else begin
              clk_cnt <= clk_cnt + cnt_one;
            end
          end
          STOP: begin
            // Reaching here in the last cycle means no pop, so go idle
            if (clk_cnt == last_cnt) begin
              state   <= IDLE;
              clk_cnt <= '0;
              tx      <= 1'b1;
              busy    <= 1'b0;
            end else begin
              clk_cnt    <= clk_cnt + cnt_one;
              frame_done <= (clk_cnt + cnt_one == last_cnt);
            end
          end
          default: begin
            state   <= IDLE;
            clk_cnt <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
